// File: rtl/edge_tick_pkg.sv
// Shared definitions for the edge_tick block: mode encodings and a counter
// width helper that stays legal when the debounce depth is 1 or 2.
package edge_tick_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    // $clog2 collapses to 0 for depths of 1, so floor the width at one bit.
    function automatic int cnt_width(input int debounce);
        return (debounce <= 2) ? 1 : $clog2(debounce);
    endfunction

endpackage

// File: rtl/edge_tick_chan.sv
// One channel of edge_tick: synchroniser, debounce filter, edge
// qualification against the runtime mode, and the sticky pending flag.
module edge_tick_chan
    import edge_tick_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       din,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       level,
    output logic       tick,
    output logic       pending
);

    localparam int CW = cnt_width(DEBOUNCE);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   lvl;
    logic [CW-1:0]          cnt;
    logic                   accept;
    logic                   qualify;

    // Synchroniser chain; din enters at bit 0 and leaves at the top bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // A level change is accepted only after the synchronised input has
    // disagreed with the stable level for DEBOUNCE consecutive cycles.
    always_comb begin
        accept = (sync != lvl) && (cnt == CW'(DEBOUNCE - 1));
    end

    // Debounce filter: any return to the stable level throws the count away.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl <= 1'b0;
            cnt <= '0;
        end else if (sync == lvl) begin
            cnt <= '0;
        end else if (accept) begin
            lvl <= sync;
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Qualify the accepted edge against the mode sampled this cycle.
    always_comb begin
        qualify = 1'b0;
        if (accept) begin
            if (sync) begin
                qualify = (mode == MODE_RISE) || (mode == MODE_BOTH);
            end else begin
                qualify = (mode == MODE_FALL) || (mode == MODE_BOTH);
            end
        end
    end

    // Registered tick and sticky pending; a new event beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick    <= 1'b0;
            pending <= 1'b0;
        end else begin
            tick    <= qualify;
            pending <= qualify | (pending & ~clr);
        end
    end

    assign level = lvl;

endmodule

// File: rtl/edge_tick.sv
// Multi-channel debounced edge detector producing per-channel tick pulses
// and sticky pending flags for interrupt/event logic.
module edge_tick
    import edge_tick_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   din,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   tick,
    output logic [CHANNELS-1:0]   pending,
    output logic                  any_pending
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        edge_tick_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .din     (din[i]),
            .mode    (mode[2*i+1:2*i]),
            .clr     (clr[i]),
            .level   (level[i]),
            .tick    (tick[i]),
            .pending (pending[i])
        );
    end

    // Summary flag for a single downstream interrupt line.
    always_comb begin
        any_pending = |pending;
    end

endmodule

// File: tb/tb_edge_tick.sv
// Bench for edge_tick at default parameters. The reference model keeps a
// history of sampled inputs: the synchronised value is the input seen
// SYNC_STAGES edges ago, and a level change is accepted when the last
// DEBOUNCE synchronised samples all differ from the current stable level.
module tb_edge_tick;

    localparam int CH = 4;
    localparam int SS = 2;
    localparam int DB = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [CH-1:0]   din = '0;
    logic [2*CH-1:0] mode = 8'h55;
    logic [CH-1:0]   clr = '0;
    logic [CH-1:0]   level;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   pending;
    logic            any_pending;

    always #5 clk = ~clk;

    edge_tick #(
        .CHANNELS    (CH),
        .SYNC_STAGES (SS),
        .DEBOUNCE    (DB)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .mode        (mode),
        .clr         (clr),
        .level       (level),
        .tick        (tick),
        .pending     (pending),
        .any_pending (any_pending)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [CH-1:0] dhist[$];
    logic [CH-1:0] shist[$];
    logic [CH-1:0] m_lvl;
    logic [CH-1:0] m_tick;
    logic [CH-1:0] m_pend;
    logic [CH-1:0] level_seen;
    int            tick_cnt[CH];
    int            w_left[CH];
    bit            found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        dhist.delete();
        shist.delete();
        for (int k = 0; k < SS; k++) dhist.push_front('0);
        for (int k = 0; k < DB; k++) shist.push_front('0);
        m_lvl  = '0;
        m_tick = '0;
        m_pend = '0;
    endtask

    task automatic clear_counts();
        for (int c = 0; c < CH; c++) tick_cnt[c] = 0;
        level_seen = '0;
    endtask

    function automatic bit qualifies(input logic [1:0] md, input bit rising);
        return rising ? md[0] : md[1];
    endfunction

    // Advance the reference model by one rising edge using current inputs.
    task automatic model_edge();
        logic [CH-1:0] cur_sync;
        logic [CH-1:0] new_tick;
        bit            all_diff;
        cur_sync = dhist[SS-1];
        shist.push_front(cur_sync);
        if (shist.size() > DB) void'(shist.pop_back());
        dhist.push_front(din);
        if (dhist.size() > SS) void'(dhist.pop_back());
        new_tick = '0;
        for (int c = 0; c < CH; c++) begin
            all_diff = 1'b1;
            for (int k = 0; k < DB; k++) begin
                if (shist[k][c] == m_lvl[c]) all_diff = 1'b0;
            end
            if (all_diff) begin
                m_lvl[c] = ~m_lvl[c];
                if (qualifies(mode[2*c +: 2], m_lvl[c])) new_tick[c] = 1'b1;
            end
        end
        m_pend = new_tick | (m_pend & ~clr);
        m_tick = new_tick;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("tick", 32'(tick), 32'(m_tick));
        chk("level", 32'(level), 32'(m_lvl));
        chk("pending", 32'(pending), 32'(m_pend));
        chk("any_pending", 32'(any_pending), 32'(|m_pend));
        for (int c = 0; c < CH; c++) if (tick[c]) tick_cnt[c]++;
        level_seen = level_seen | level;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        // Reset with all inputs high, then expect a rise on every channel.
        model_reset();
        clear_counts();
        rst_n = 1'b0;
        din   = 4'hF;
        mode  = 8'h55;
        #12;
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_tick", 32'(tick), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_any", 32'(any_pending), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        steps(4);
        chk("pre_latency_level", 32'(level), 32'h0);
        step();
        chk("latency_tick", 32'(tick), 32'hF);
        chk("latency_level", 32'(level), 32'hF);
        step();
        chk("tick_one_cycle", 32'(tick), 32'h0);

        // Glitch suppression on channel 0.
        din = 4'h0;
        steps(10);
        clear_counts();
        din = 4'b0001;
        steps(2);
        din = 4'h0;
        steps(10);
        chk("glitch2_ticks", 32'(tick_cnt[0]), 32'd0);
        chk("glitch2_level", 32'(level_seen[0]), 32'd0);
        din = 4'b0001;
        steps(3);
        din = 4'h0;
        steps(2);
        chk("pulse3_tick", 32'(tick[0]), 32'd1);
        steps(10);
        chk("pulse3_ticks", 32'(tick_cnt[0]), 32'd1);
        chk("pulse3_fall_level", 32'(level[0]), 32'd0);

        // Per-channel modes: off, rise, fall, both.
        mode = 8'hE4;
        clear_counts();
        din = 4'hF;
        steps(10);
        chk("modes_level_high", 32'(level), 32'hF);
        din = 4'h0;
        steps(10);
        chk("modes_level_low", 32'(level), 32'h0);
        chk("mode_off_ticks", 32'(tick_cnt[0]), 32'd0);
        chk("mode_rise_ticks", 32'(tick_cnt[1]), 32'd1);
        chk("mode_fall_ticks", 32'(tick_cnt[2]), 32'd1);
        chk("mode_both_ticks", 32'(tick_cnt[3]), 32'd2);

        // Pending set, clear, and set-beats-clear.
        clr = 4'hF;
        step();
        clr = 4'h0;
        chk("pend_cleared_all", 32'(pending), 32'h0);
        din = 4'b0100;
        steps(10);
        din = 4'h0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (tick[2]) found = 1'b1;
        end
        chk("pend_tick_seen", 32'(found), 32'd1);
        chk("pend_set", 32'(pending), 32'b0100);
        chk("pend_any", 32'(any_pending), 32'd1);
        clr = 4'b0100;
        step();
        clr = 4'h0;
        chk("pend_clr", 32'(pending), 32'h0);
        chk("pend_clr_any", 32'(any_pending), 32'd0);
        din = 4'b0100;
        steps(10);
        din = 4'h0;
        clr = 4'b0100;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            step();
            if (tick[2]) found = 1'b1;
        end
        chk("setclr_tick_seen", 32'(found), 32'd1);
        chk("setclr_set_wins", 32'(pending[2]), 32'd1);
        step();
        chk("setclr_then_clear", 32'(pending[2]), 32'd0);
        clr = 4'h0;

        // Asynchronous reset while channel 1 is two counts into debounce.
        din = 4'b0010;
        steps(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_level", 32'(level), 32'h0);
        chk("midrst_tick", 32'(tick), 32'h0);
        chk("midrst_pending", 32'(pending), 32'h0);
        model_reset();
        din = 4'h0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        clear_counts();
        steps(10);
        chk("midrst_no_tick", 32'(tick_cnt[1]), 32'd0);
        chk("midrst_no_level", 32'(level_seen), 32'h0);

        // Random pulse widths 1..8 per channel, random modes and clears.
        for (int c = 0; c < CH; c++) w_left[c] = int'($urandom_range(1, 8));
        for (int cyc = 0; cyc < 2000; cyc++) begin
            if (cyc % 200 == 0) mode = 8'($urandom);
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
            for (int c = 0; c < CH; c++) begin
                w_left[c]--;
                if (w_left[c] <= 0) begin
                    din[c]    = ~din[c];
                    w_left[c] = int'($urandom_range(1, 8));
                end
            end
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
